// File: rtl/key_irq_pkg.sv
// Shared types and helpers for the key interrupt controller.
package key_irq_pkg;

    localparam int unsigned VEC_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

    // Vector address of key idx; wraps to VEC_W bits.
    function automatic logic [VEC_W-1:0] vec_of(input int unsigned idx,
                                                 input int unsigned base,
                                                 input int unsigned stride);
        return VEC_W'(base + stride * idx);
    endfunction

endpackage

// File: rtl/key_irq_ctrl_if.sv
// CPU interrupt handshake: enable/ack from the CPU, request/vector to it.
interface key_irq_ctrl_if;
    import key_irq_pkg::*;

    logic             irq_en;
    logic             irq_ack;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;

    modport master (output irq_en, output irq_ack, input irq_req, input irq_vec);
    modport slave  (input irq_en, input irq_ack, output irq_req, output irq_vec);

endinterface

// File: rtl/key_debounce_repeat.sv
// One key: 2-FF synchroniser, tick-based debounce and press/auto-repeat event FSM.
module key_debounce_repeat
    import key_irq_pkg::*;
#(
    parameter int unsigned DEB_TICKS  = 4,
    parameter int unsigned REP_DELAY  = 32,
    parameter int unsigned REP_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic key_n_i,
    output logic key_level_o,
    output logic evt_o
);

    localparam int unsigned DEB_W   = $clog2(DEB_TICKS + 1);
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX < 1) ? 1 : $clog2(REP_MAX + 1);
    localparam bit          REP_EN  = (REP_PERIOD != 0);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    key_state_e       state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             evt_q, evt_d;

    logic sample_c, rise_c, fall_c, rep_zero_c;

    assign sample_c   = ~sync_q[1];
    assign rise_c     = level_d & ~level_q;
    assign fall_c     = level_q & ~level_d;
    assign rep_zero_c = (rep_q <= REP_W'(1));

    // Debounce: level toggles after DEB_TICKS consecutive differing samples.
    always_comb begin
        level_d = level_q;
        deb_d   = deb_q;
        if (tick_i) begin
            if (sample_c == level_q) begin
                deb_d = '0;
            end else if (deb_q == DEB_W'(DEB_TICKS - 1)) begin
                level_d = ~level_q;
                deb_d   = '0;
            end else begin
                deb_d = deb_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b0;
            deb_q   <= '0;
            state_q <= IDLE;
            rep_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            level_q <= level_d;
            deb_q   <= deb_d;
            state_q <= state_d;
            rep_q   <= rep_d;
            evt_q   <= evt_d;
        end
    end

    // Next state: a falling level always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (fall_c) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise_c) state_d = HELD;
                HELD:    if (tick_i && rep_zero_c && REP_EN) state_d = REPEAT;
                REPEAT:  state_d = REPEAT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Repeat counter and event generation; release never emits.
    always_comb begin
        rep_d = rep_q;
        evt_d = 1'b0;
        if (!fall_c) begin
            case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        evt_d = 1'b1;
                        rep_d = REP_W'(REP_DELAY);
                    end
                end
                HELD: begin
                    if (tick_i) begin
                        if (!rep_zero_c) begin
                            rep_d = rep_q - REP_W'(1);
                        end else begin
                            evt_d = REP_EN;
                            rep_d = REP_W'(REP_PERIOD);
                        end
                    end
                end
                REPEAT: begin
                    if (tick_i) begin
                        if (!rep_zero_c) begin
                            rep_d = rep_q - REP_W'(1);
                        end else begin
                            evt_d = 1'b1;
                            rep_d = REP_W'(REP_PERIOD);
                        end
                    end
                end
                default: rep_d = '0;
            endcase
        end
    end

    assign key_level_o = level_q;
    assign evt_o       = evt_q;

endmodule

// File: rtl/key_irq_ctrl.sv
// Key interrupt controller: tick divider, per-key pending bits, priority
// encoder and the request/ack handshake towards the CPU.
module key_irq_ctrl
    import key_irq_pkg::*;
#(
    parameter int unsigned NKEYS      = 6,
    parameter int unsigned TICK_DIV   = 1024,
    parameter int unsigned DEB_TICKS  = 4,
    parameter int unsigned REP_DELAY  = 32,
    parameter int unsigned REP_PERIOD = 8,
    parameter int unsigned VEC_BASE   = 2,
    parameter int unsigned VEC_STRIDE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keys_n,
    output logic [NKEYS-1:0] key_level,
    output logic             evt_lost,
    key_irq_ctrl_if.slave    bus
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned IDX_W  = (NKEYS > 1) ? $clog2(NKEYS) : 1;

    logic [TICK_W-1:0] div_q, div_d;
    logic              tick_c;
    logic [NKEYS-1:0]  evt;
    logic [NKEYS-1:0]  pending_q, pending_d;
    logic [NKEYS-1:0]  clr_c;
    logic              lost_q, lost_d;
    logic              req_q, req_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [IDX_W-1:0]  first_idx_c;
    logic              any_c;

    assign tick_c = (div_q == TICK_W'(TICK_DIV - 1));
    assign div_d  = tick_c ? '0 : div_q + TICK_W'(1);

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce_repeat #(
            .DEB_TICKS (DEB_TICKS),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD)
        ) u_key (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (tick_c),
            .key_n_i    (keys_n[g]),
            .key_level_o(key_level[g]),
            .evt_o      (evt[g])
        );
    end

    // Lowest set pending index wins.
    always_comb begin
        first_idx_c = '0;
        for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
            if (pending_q[i]) first_idx_c = IDX_W'(i);
        end
    end

    assign any_c = |pending_q;

    // A new event on the same key as the ack keeps the bit set and is not lost.
    always_comb begin
        clr_c     = (req_q && bus.irq_ack) ? (NKEYS'(1) << idx_q) : '0;
        pending_d = (pending_q & ~clr_c) | evt;
        lost_d    = |(evt & pending_q & ~clr_c);
    end

    // Handshake: the latched index and vector hold until the ack.
    always_comb begin
        req_d = req_q;
        idx_d = idx_q;
        vec_d = vec_q;
        if (req_q) begin
            if (bus.irq_ack) req_d = 1'b0;
        end else if (bus.irq_en && any_c) begin
            req_d = 1'b1;
            idx_d = first_idx_c;
            vec_d = vec_of(32'(first_idx_c), VEC_BASE, VEC_STRIDE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= '0;
            pending_q <= '0;
            lost_q    <= 1'b0;
            req_q     <= 1'b0;
            idx_q     <= '0;
            vec_q     <= '0;
        end else begin
            div_q     <= div_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            vec_q     <= vec_d;
        end
    end

    assign bus.irq_req = req_q;
    assign bus.irq_vec = vec_q;
    assign evt_lost    = lost_q;

endmodule

// File: doc/key_irq_ctrl.md
Name: key_irq_ctrl

Overview:
- Input side of the matrix CPU's interrupt interface. Samples the raw active-low buttons, debounces them and generates press and auto-repeat events per key.
- Holds one pending bit per key and presents a single prioritised vector request (irq_req/irq_vec) to the CPU. The request is held until the CPU acknowledges it.
- Replaces the CPU's level-sensitive button polling and adds the missing key-repeat function.

Parameters:
- NKEYS, 6: number of keys; index 0 has highest priority.
- TICK_DIV, 1024: clk cycles per sample tick; must be >= 2.
- DEB_TICKS, 4: consecutive equal samples needed before the debounced level changes; must be >= 1.
- REP_DELAY, 32: ticks from a debounced press to the first repeat event.
- REP_PERIOD, 8: ticks between later repeat events; 0 disables repeat.
- VEC_BASE, 2: vector address of key 0.
- VEC_STRIDE, 2: vector spacing between keys.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-low.
- keys_n, input, NKEYS: raw buttons, 0 = pressed, asynchronous to clk.
- irq_en, input, 1: 1 = CPU accepts interrupts (inverse of the CPU di flag).
- irq_ack, input, 1: one-cycle pulse, CPU has taken the current vector.
- irq_req, output, 1: vector request.
- irq_vec, output, 8: vector address, valid while irq_req = 1.
- key_level, output, NKEYS: debounced level, 1 = pressed.
- evt_lost, output, 1: one-cycle pulse when an event hits a key whose pending bit is already set.

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-low. Ports are named clk and rst.
- Reset (rst = 0 at a clk edge) clears all state:
  - irq_req = 0, irq_vec = 0, key_level = 0, evt_lost = 0.
  - Pending bits, per-key FSMs, debounce counters and the tick divider all return to initial values.
  - Reset in mid-request drops the request with no ack required.
- Synchronisation: keys_n passes through a 2-FF synchroniser and is inverted. The synchroniser is not reset-dependent for correctness.
- Tick: the divider counts 0..TICK_DIV-1; tick is a one-cycle pulse when count = TICK_DIV-1, after which the count wraps to 0.
- Debounce, on each tick, per key:
  - If the synchronised sample equals key_level, the counter clears.
  - Otherwise the counter increments. When it reaches DEB_TICKS, key_level toggles and the counter clears.
- Per-key FSM, advancing only on ticks except where stated; states IDLE, HELD, REPEAT:
  - IDLE -> HELD when key_level rises. Emits a press event and loads the repeat counter with REP_DELAY.
  - HELD: decrement on each tick. At 0: if REP_PERIOD != 0, emit an event, load REP_PERIOD and go to REPEAT; otherwise stay in HELD.
  - REPEAT: decrement on each tick; at 0, emit an event and reload REP_PERIOD.
  - Any state -> IDLE in the cycle key_level falls. Release generates no event.
- Pending bits:
  - An event sets pending[i] in the next cycle.
  - Event on an already-set bit: the bit stays set and evt_lost pulses (events coalesce).
  - Event and ack for the same key in the same cycle: set wins, no evt_lost.
- Request handshake:
  - When irq_req = 0, irq_en = 1 and any pending bit is set, the next cycle gives irq_req = 1. irq_vec = VEC_BASE + VEC_STRIDE*i (8-bit wrap), where i is the lowest set index; i is latched.
  - irq_vec and the latched index stay stable until ack, even if a higher-priority key becomes pending.
  - irq_ack while irq_req = 1: clear pending[latched], irq_req = 0 next cycle. At least one idle cycle separates consecutive requests.
  - irq_ack while irq_req = 0: ignored.
  - irq_en falling while irq_req = 1: the request is held (already committed). No new request rises while irq_en = 0; pending bits still accumulate.

Decomposition:
- Package key_irq_pkg holds the FSM state enum (IDLE/HELD/REPEAT), the vector width constant (8) and a function vec_of(i).
- One sub-module, key_debounce_repeat, instantiated NKEYS times. It covers synchroniser, debounce, FSM and repeat counter, with outputs key_level and evt.
- The top level holds the tick divider, pending bits, priority encoder and handshake.

Test Plan:
All scenarios use TICK_DIV = 4, DEB_TICKS = 3, REP_DELAY = 8, REP_PERIOD = 4, NKEYS = 6.
1. Bounce: keys_n[1] toggles every 5 cycles for 40 cycles, then is held low -> key_level[1] rises about 12 cycles after the stable low; exactly one irq_req with irq_vec = 4; no further request before the repeat delay.
2. Auto-repeat: hold key 0 for 100 cycles, acking each request 3 cycles after irq_req rises -> vec = 2 at press, again about 32 cycles later, then every 16 cycles; release gives no event.
3. Priority/stability: keys 3 and 5 pending with irq_en = 0, then irq_en = 1 -> vec 8; key 0 pressed before the ack leaves irq_vec = 8 until ack; then vec 2, then vec 12.
4. Coalesce: key 2 repeating while never acked -> irq_req stays high, irq_vec = 6, evt_lost pulses once per repeat event.
5. Event and ack in the same cycle on key 0 -> pending stays set; irq_req falls for one cycle, then rises again with vec 2; evt_lost = 0.
6. Reset: rst = 0 for 1 cycle while irq_req = 1 and key 4 is held -> all outputs 0 the next cycle; a new press event for key 4 after re-debounce gives vec 10.
